// File: rtl/sc_scratchpad_regfile.sv
// -----------------------------------------------------------------------------
// sc_scratchpad_regfile
//
// Scratchpad register bank of the microprogrammed datapath. Sixteen registers
// r0..r15 drive the sixteen data inputs of the A/B source-selection muxes
// directly. r0 is hard-wired to zero. Registers r1..r15 are written from the
// C bus under microinstruction control.
//
// A microcode-triggered bulk clear zeroes r1..r15, one register per cycle.
// While it runs, Busy_Out is high and all writes are dropped.
//
// Optional feature: define SC_SCRATCHPAD_BYPASS_EN to enable write-through
// forwarding. With it, a committing write is visible on its output bus in the
// same cycle. When the macro is not defined, outputs are pure register
// contents.
//
// Ports:
//   SC_SCRATCHPAD_CLOCK_50          system clock (rising edge)
//   SC_SCRATCHPAD_RESET_InHigh      asynchronous active-high reset
//   SC_SCRATCHPAD_DataBusC_InBus    write data from the C bus
//   SC_SCRATCHPAD_CSelection_InBus  write target index (only 1..15 write)
//   SC_SCRATCHPAD_Write_In          write strobe
//   SC_SCRATCHPAD_Clear_In          start bulk clear (level-sampled in IDLE)
//   SC_SCRATCHPAD_Busy_Out          registered, high while bulk clear runs
//   SC_SCRATCHPAD_dataK_OutBus      contents of rK, K = 0..15
// -----------------------------------------------------------------------------
module sc_scratchpad_regfile #(
    parameter int DATAWIDTH_BUS         = 32,
    parameter int DATAWIDTH_C_SELECTION = 6
) (
    input  logic                             SC_SCRATCHPAD_CLOCK_50,
    input  logic                             SC_SCRATCHPAD_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_DataBusC_InBus,
    input  logic [DATAWIDTH_C_SELECTION-1:0] SC_SCRATCHPAD_CSelection_InBus,
    input  logic                             SC_SCRATCHPAD_Write_In,
    input  logic                             SC_SCRATCHPAD_Clear_In,
    output logic                             SC_SCRATCHPAD_Busy_Out,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data0_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data1_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data2_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data3_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data4_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data5_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data6_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data7_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data8_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data9_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data10_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data11_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data12_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data13_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data14_OutBus,
    output logic [DATAWIDTH_BUS-1:0]         SC_SCRATCHPAD_data15_OutBus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [3:0]               pointer;
    logic [3:0]               next_pointer;
    logic                     busy;
    logic                     clear_en;
    logic                     write_en;
    logic                     index_ok;
    logic [DATAWIDTH_BUS-1:0] regs [1:15];
    logic [DATAWIDTH_BUS-1:0] view [0:15];

    // Index 0 and 16..63 never write; the compare is done at 32 bits so the
    // select width can be any size.
    assign index_ok = (SC_SCRATCHPAD_CSelection_InBus != '0) &&
                      (32'(SC_SCRATCHPAD_CSelection_InBus) < 32'd16);

    // State register. Busy is registered from next_state so it is high
    // exactly in the cycles the FSM spends in CLEAR.
    always_ff @(posedge SC_SCRATCHPAD_CLOCK_50 or posedge SC_SCRATCHPAD_RESET_InHigh) begin
        if (SC_SCRATCHPAD_RESET_InHigh) begin
            state   <= IDLE;
            pointer <= 4'd1;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            pointer <= next_pointer;
            busy    <= (next_state == CLEAR);
        end
    end

    // Next-state logic. Clear_In is only looked at in IDLE, so holding it
    // high through CLEAR cannot restart the sequence.
    always_comb begin
        next_state   = state;
        next_pointer = pointer;
        case (state)
            IDLE: begin
                if (SC_SCRATCHPAD_Clear_In) begin
                    next_state   = CLEAR;
                    next_pointer = 4'd1;
                end
            end
            CLEAR: begin
                if (pointer == 4'd15) begin
                    next_state   = IDLE;
                    next_pointer = 4'd1;
                end else begin
                    next_pointer = pointer + 4'd1;
                end
            end
            default: begin
                next_state   = IDLE;
                next_pointer = 4'd1;
            end
        endcase
    end

    // Output / datapath-control decode. Clear takes priority over a write
    // requested in the same IDLE cycle.
    always_comb begin
        clear_en = (state == CLEAR);
        write_en = (state == IDLE) && !SC_SCRATCHPAD_Clear_In &&
                   SC_SCRATCHPAD_Write_In && index_ok;
    end

    // Register bank r1..r15. r0 has no storage at all.
    always_ff @(posedge SC_SCRATCHPAD_CLOCK_50 or posedge SC_SCRATCHPAD_RESET_InHigh) begin
        if (SC_SCRATCHPAD_RESET_InHigh) begin
            for (int k = 1; k < 16; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < 16; k++) begin
                if (clear_en && (pointer == 4'(k))) begin
                    regs[k] <= '0;
                end else if (write_en &&
                             (SC_SCRATCHPAD_CSelection_InBus == DATAWIDTH_C_SELECTION'(k))) begin
                    regs[k] <= SC_SCRATCHPAD_DataBusC_InBus;
                end
            end
        end
    end

    // Output view. write_en already excludes r0, CLEAR and Clear_In=1, so the
    // forwarding path needs no further qualification.
    always_comb begin
        view[0] = '0;
        for (int k = 1; k < 16; k++) begin
`ifdef SC_SCRATCHPAD_BYPASS_EN
            if (write_en && (SC_SCRATCHPAD_CSelection_InBus == DATAWIDTH_C_SELECTION'(k))) begin
                view[k] = SC_SCRATCHPAD_DataBusC_InBus;
            end else begin
                view[k] = regs[k];
            end
`else
            view[k] = regs[k];
`endif
        end
    end

    assign SC_SCRATCHPAD_Busy_Out     = busy;
    assign SC_SCRATCHPAD_data0_OutBus  = view[0];
    assign SC_SCRATCHPAD_data1_OutBus  = view[1];
    assign SC_SCRATCHPAD_data2_OutBus  = view[2];
    assign SC_SCRATCHPAD_data3_OutBus  = view[3];
    assign SC_SCRATCHPAD_data4_OutBus  = view[4];
    assign SC_SCRATCHPAD_data5_OutBus  = view[5];
    assign SC_SCRATCHPAD_data6_OutBus  = view[6];
    assign SC_SCRATCHPAD_data7_OutBus  = view[7];
    assign SC_SCRATCHPAD_data8_OutBus  = view[8];
    assign SC_SCRATCHPAD_data9_OutBus  = view[9];
    assign SC_SCRATCHPAD_data10_OutBus = view[10];
    assign SC_SCRATCHPAD_data11_OutBus = view[11];
    assign SC_SCRATCHPAD_data12_OutBus = view[12];
    assign SC_SCRATCHPAD_data13_OutBus = view[13];
    assign SC_SCRATCHPAD_data14_OutBus = view[14];
    assign SC_SCRATCHPAD_data15_OutBus = view[15];

endmodule

// File: tb/tb_sc_scratchpad_regfile.sv
// -----------------------------------------------------------------------------
// tb_sc_scratchpad_regfile
//
// Self-checking bench for sc_scratchpad_regfile. A behavioural model (array
// of register values plus a "which register is cleared next" index) predicts
// every output before and after each clock edge. Directed steps cover the
// reset state, plain writes, writes to index 0 and out-of-range indices, bulk
// clear timing, clear/write collision and asynchronous reset mid-clear. They
// are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_sc_scratchpad_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] dat;
    logic [5:0]  sel;
    logic        wr;
    logic        clr;
    logic        busy;
    wire  [31:0] dout [16];

    int total;
    int bad;

    // Reference model state.
    logic [31:0] mem [16];
    int          clr_idx;     // 0 = idle, else next register to be zeroed
    logic [31:0] exp_out [16];
    logic        exp_busy;

    sc_scratchpad_regfile #(
        .DATAWIDTH_BUS(32),
        .DATAWIDTH_C_SELECTION(6)
    ) dut (
        .SC_SCRATCHPAD_CLOCK_50(clk),
        .SC_SCRATCHPAD_RESET_InHigh(rst),
        .SC_SCRATCHPAD_DataBusC_InBus(dat),
        .SC_SCRATCHPAD_CSelection_InBus(sel),
        .SC_SCRATCHPAD_Write_In(wr),
        .SC_SCRATCHPAD_Clear_In(clr),
        .SC_SCRATCHPAD_Busy_Out(busy),
        .SC_SCRATCHPAD_data0_OutBus(dout[0]),
        .SC_SCRATCHPAD_data1_OutBus(dout[1]),
        .SC_SCRATCHPAD_data2_OutBus(dout[2]),
        .SC_SCRATCHPAD_data3_OutBus(dout[3]),
        .SC_SCRATCHPAD_data4_OutBus(dout[4]),
        .SC_SCRATCHPAD_data5_OutBus(dout[5]),
        .SC_SCRATCHPAD_data6_OutBus(dout[6]),
        .SC_SCRATCHPAD_data7_OutBus(dout[7]),
        .SC_SCRATCHPAD_data8_OutBus(dout[8]),
        .SC_SCRATCHPAD_data9_OutBus(dout[9]),
        .SC_SCRATCHPAD_data10_OutBus(dout[10]),
        .SC_SCRATCHPAD_data11_OutBus(dout[11]),
        .SC_SCRATCHPAD_data12_OutBus(dout[12]),
        .SC_SCRATCHPAD_data13_OutBus(dout[13]),
        .SC_SCRATCHPAD_data14_OutBus(dout[14]),
        .SC_SCRATCHPAD_data15_OutBus(dout[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every output bus and Busy against the expected arrays.
    task automatic check_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            total++;
            assert (dout[k] === exp_out[k]) else begin
                bad++;
                $error("FAIL %s data%0d observed=%08h expected=%08h", tag, k, dout[k], exp_out[k]);
            end
        end
        total++;
        assert (busy === exp_busy) else begin
            bad++;
            $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, exp_busy);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) mem[k] = 32'h0;
        clr_idx = 0;
    endtask

    task automatic load_expected();
        for (int k = 0; k < 16; k++) exp_out[k] = mem[k];
        exp_busy = (clr_idx != 0);
    endtask

    // One clock cycle: apply inputs, check the pre-edge view, advance the
    // model by the rules of the bank, then check the post-edge view.
    task automatic tick(input logic w, input logic [5:0] s, input logic [31:0] d,
                        input logic c, input string tag);
        bit commit;
        wr  = w;
        sel = s;
        dat = d;
        clr = c;
        #1;
        commit = (clr_idx == 0) && !c && w && (s >= 6'd1) && (s <= 6'd15);
        load_expected();
`ifdef SC_SCRATCHPAD_BYPASS_EN
        if (commit) exp_out[s[3:0]] = d;
`endif
        check_all({tag, "_pre"});
        if (clr_idx != 0) begin
            mem[clr_idx] = 32'h0;
            clr_idx = (clr_idx == 15) ? 0 : clr_idx + 1;
        end else if (c) begin
            clr_idx = 1;
        end else if (commit) begin
            mem[s[3:0]] = d;
        end
        @(posedge clk);
        #1;
        load_expected();
        check_all({tag, "_post"});
    endtask

    initial begin
        int busy_cycles;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        wr  = 1'b0;
        clr = 1'b0;
        sel = 6'd0;
        dat = 32'h0;
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        load_expected();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write, one cycle latency.
        tick(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, "wr5");
        tick(1'b0, 6'd5, 32'h0, 1'b0, "idle");
        total++;
        assert (dout[5] === 32'hDEADBEEF) else begin
            bad++;
            $error("FAIL wr5_value observed=%08h expected=%08h", dout[5], 32'hDEADBEEF);
        end

        // Writes to index 0 and an out-of-range index are discarded.
        tick(1'b1, 6'd0,  32'hFFFFFFFF, 1'b0, "wr0");
        tick(1'b1, 6'd20, 32'hFFFFFFFF, 1'b0, "wr20");
        tick(1'b1, 6'd63, 32'hFFFFFFFF, 1'b0, "wr63");

        // Back-to-back writes to the same register.
        tick(1'b1, 6'd9, 32'h0000CAFE, 1'b0, "wr9a");
        tick(1'b1, 6'd9, 32'h12345678, 1'b0, "wr9b");

        // Fill r1..r15, then bulk clear; a write during CLEAR is lost.
        for (int k = 1; k < 16; k++) tick(1'b1, 6'(k), 32'h11111111 * k, 1'b0, "fill");
        tick(1'b0, 6'd0, 32'h0, 1'b1, "clr_start");
        busy_cycles = 0;
        for (int k = 1; k < 16; k++) begin
            if (busy === 1'b1) busy_cycles++;
            tick(k == 4, 6'd14, 32'hBAD0BAD0, k == 9, "clearing");
        end
        total++;
        assert (busy_cycles == 15) else begin
            bad++;
            $error("FAIL busy_len observed=%0d expected=%0d", busy_cycles, 15);
        end
        tick(1'b1, 6'd7, 32'hA5A5A5A5, 1'b0, "wr_after_clr");

        // Clear and write in the same IDLE cycle: clear wins.
        tick(1'b1, 6'd3, 32'h33333333, 1'b1, "clr_wr_same");
        for (int k = 1; k < 16; k++) tick(1'b0, 6'd0, 32'h0, 1'b0, "clear2");
        tick(1'b0, 6'd0, 32'h0, 1'b0, "idle2");

        // Asynchronous reset when the pointer is at 7.
        for (int k = 1; k < 16; k++) tick(1'b1, 6'(k), 32'hC0DE0000 + k, 1'b0, "fill2");
        tick(1'b0, 6'd0, 32'h0, 1'b1, "clr3_start");
        for (int k = 1; k < 7; k++) tick(1'b0, 6'd0, 32'h0, 1'b0, "clear3");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        load_expected();
        check_all("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all("after_rst");
        @(posedge clk);
        #1;
        tick(1'b1, 6'd8, 32'h88888888, 1'b0, "wr_after_rst");

        // Randomized run.
        for (int n = 0; n < 400; n++) begin
            logic        rw;
            logic        rc;
            logic [5:0]  rs;
            logic [31:0] rd;
            rw = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 15));
            rd = $urandom;
            tick(rw, rs, rd, rc, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
